// File: rtl/nios2mypio_mem_arb_pkg.sv
// Shared widths, FSM state type and master index type for the on-chip RAM arbiter.
package nios2mypio_mem_arb_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef logic mst_idx_t;

endpackage

// File: rtl/nios2mypio_rr_arb2.sv
// Two-master round-robin grant with a bounded lock: the owner keeps exclusive
// eligibility until it drops lock, goes idle unlocked, or the lock budget runs out.
module nios2mypio_rr_arb2
  import nios2mypio_mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     req0,
  input  logic     req1,
  input  logic     lock0,
  input  logic     lock1,
  output logic     gnt0,
  output logic     gnt1,
  output mst_idx_t win
);

  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_LOCK > 0) ? MAX_LOCK - 1 : 0);
  localparam bit LOCK_EN = (MAX_LOCK != 0);

  arb_state_e       state_q, state_d;
  mst_idx_t         owner_q, owner_d;
  mst_idx_t         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic cand0, cand1, accept, win_lock, own_req, own_lock;

  always_comb begin
    cand0    = req0 & ((state_q == ST_IDLE) | (owner_q == 1'b0));
    cand1    = req1 & ((state_q == ST_IDLE) | (owner_q == 1'b1));
    win      = (cand0 & cand1) ? rr_ptr_q : cand1;
    // Nothing is granted while reset is held, so the RAM never sees a strobe.
    accept   = (cand0 | cand1) & reset_n;
    gnt0     = accept & (win == 1'b0);
    gnt1     = accept & (win == 1'b1);
    win_lock = win ? lock1 : lock0;
    own_req  = owner_q ? req1 : req0;
    own_lock = owner_q ? lock1 : lock0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rr_ptr_d = ~win;
          if (win_lock && LOCK_EN) begin
            state_d    = ST_LOCKED;
            owner_d    = win;
            lock_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if ((accept & ~own_lock) | (~own_req & ~own_lock) | (lock_cnt_q == CNT_LAST)) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = ~owner_q;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/nios2mypio_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters: winner's pins are
// muxed to the RAM combinationally and read data is routed back one cycle later.
module nios2mypio_onchip_mem_arbiter #(
  parameter  int ADDR_W   = nios2mypio_mem_arb_pkg::ADDR_W,
  parameter  int DATA_W   = nios2mypio_mem_arb_pkg::DATA_W,
  parameter  int MAX_LOCK = 16,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  import nios2mypio_mem_arb_pkg::*;

  logic     gnt0, gnt1;
  mst_idx_t win;
  logic     rd_v_q, rd_v_d;
  mst_idx_t rd_own_q, rd_own_d;

  nios2mypio_rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (m0_read | m0_write),
    .req1    (m1_read | m1_write),
    .lock0   (m0_lock),
    .lock1   (m1_lock),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .win     (win)
  );

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;
  assign mem_clken      = reset_n;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    rd_v_d         = 1'b0;
    rd_own_d       = rd_own_q;
    if (gnt0 | gnt1) begin
      mem_chipselect = 1'b1;
      rd_own_d       = win;
      // Read+write together is taken as a write and never returns data.
      if (win == 1'b0) begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_write      = m0_write;
        mem_writedata  = m0_writedata;
        rd_v_d         = m0_read & ~m0_write;
      end else begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_write      = m1_write;
        mem_writedata  = m1_writedata;
        rd_v_d         = m1_read & ~m1_write;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v_q   <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      rd_v_q   <= rd_v_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign m0_readdatavalid = rd_v_q & (rd_own_q == 1'b0);
  assign m1_readdatavalid = rd_v_q & (rd_own_q == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nios2mypio_onchip_mem_arbiter.sv
// Directed bench for the two-master RAM arbiter with a transaction-level reference model.
module tb_nios2mypio_onchip_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int ML = 16;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          lk;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } mreq_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mreq_t q0 = '0, q1 = '0;
  logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic mem_chipselect, mem_write, mem_clken;

  nios2mypio_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(q0.a), .m0_byteenable(q0.be), .m0_read(q0.rd), .m0_write(q0.wr),
    .m0_writedata(q0.d), .m0_lock(q0.lk), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(q1.a), .m1_byteenable(q1.be), .m1_read(q1.rd), .m1_write(q1.wr),
    .m1_writedata(q1.d), .m1_lock(q1.lk), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM: registered address, unregistered data out.
  logic [DW-1:0] ram [2048];
  logic [AW-1:0] ram_a;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_a <= mem_address;
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[ram_a];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: who holds the lock, for how long, whose turn it is, pending read.
  int            lk_holder, lk_age, rr, pend_own;
  logic [DW-1:0] pend_dat;
  logic [DW-1:0] shadow [2048];

  function automatic mreq_t req_of(input int i);
    return (i == 0) ? q0 : q1;
  endfunction

  function automatic int pick();
    bit r0, r1;
    r0 = (q0.rd || q0.wr) && (lk_holder != 1);
    r1 = (q1.rd || q1.wr) && (lk_holder != 0);
    if (r0 && r1) return rr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int w;
    mreq_t x, h;
    logic [DW-1:0] nv;
    if (!reset_n) begin
      lk_holder <= -1; lk_age <= 0; rr <= 0; pend_own <= -1;
    end else begin
      w = pick();
      x = (w >= 0) ? req_of(w) : '0;
      pend_own <= -1;
      if (w >= 0) begin
        if (x.wr) begin
          nv = shadow[x.a];
          for (int b = 0; b < BW; b++) if (x.be[b]) nv[8*b +: 8] = x.d[8*b +: 8];
          shadow[x.a] <= nv;
        end else if (x.rd) begin
          pend_own <= w;
          pend_dat <= shadow[x.a];
        end
      end
      if (lk_holder < 0) begin
        if (w >= 0) begin
          rr <= 1 - w;
          if (x.lk && ML > 0) begin lk_holder <= w; lk_age <= 0; end
        end
      end else begin
        h = req_of(lk_holder);
        if (!h.lk || lk_age == ML - 1) begin rr <= 1 - lk_holder; lk_holder <= -1; end
        else lk_age <= lk_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    mreq_t x;
    if (!reset_n) begin
      chk("rst_wait0", 64'(m0_waitrequest), 64'(1));
      chk("rst_wait1", 64'(m1_waitrequest), 64'(1));
      chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
      chk("rst_cs_clken", 64'({mem_chipselect, mem_clken}), 64'(0));
    end else begin
      w = pick();
      x = (w >= 0) ? req_of(w) : '0;
      chk("wait0", 64'(m0_waitrequest), 64'(w != 0));
      chk("wait1", 64'(m1_waitrequest), 64'(w != 1));
      chk("cs", 64'(mem_chipselect), 64'(w >= 0));
      chk("mem_write", 64'(mem_write), 64'(x.wr));
      chk("mem_pins", {mem_address, mem_byteenable, mem_writedata}, {x.a, x.be, x.d});
      chk("clken", 64'(mem_clken), 64'(1));
      chk("rdv0", 64'(m0_readdatavalid), 64'(pend_own == 0));
      chk("rdv1", 64'(m1_readdatavalid), 64'(pend_own == 1));
      if (pend_own >= 0)
        chk("rdata", 64'(pend_own == 0 ? m0_readdata : m1_readdata), 64'(pend_dat));
    end
  end

  function automatic mreq_t rq(input bit rd, input bit wr, input bit lk, input int a,
                               input logic [BW-1:0] be, input logic [DW-1:0] d);
    mreq_t r;
    r.rd = rd; r.wr = wr; r.lk = lk; r.a = AW'(a); r.be = be; r.d = d;
    return r;
  endfunction

  task automatic drive(input mreq_t a, input mreq_t b);
    @(posedge clk); #1;
    q0 = a; q1 = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; q0 = '0; q1 = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    bit found;
    repeat (2) @(negedge clk);
    chk("t0_wait0", 64'(m0_waitrequest), 64'(1));
    chk("t0_clken", 64'(mem_clken), 64'(0));
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: write then read back, data returned only to m0
    drive(rq(0, 1, 0, 'h010, 4'hF, 32'hDEADBEEF), '0);
    chk("t1_wr_wait0", 64'(m0_waitrequest), 64'(0));
    chk("t1_wr_pins", 64'({mem_chipselect, mem_write}), 64'(2'b11));
    drive(rq(1, 0, 0, 'h010, 4'hF, 0), '0);
    chk("t1_rd_wait0", 64'(m0_waitrequest), 64'(0));
    drive('0, '0);
    chk("t1_rdv0", 64'(m0_readdatavalid), 64'(1));
    chk("t1_rdata", 64'(m0_readdata), 64'(32'hDEADBEEF));
    chk("t1_rdv1", 64'(m1_readdatavalid), 64'(0));

    // 2: simultaneous reads alternate, starting from m0 after reset
    drive(rq(0, 1, 0, 'h001, 4'hF, 32'h11111111), '0);
    drive(rq(0, 1, 0, 'h002, 4'hF, 32'h22222222), '0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(rq(1, 0, 0, 'h001, 4'hF, 0), rq(1, 0, 0, 'h002, 4'hF, 0));
      chk("t2_grant", 64'(m0_waitrequest), 64'(i % 2));
      if (i > 0) chk("t2_route", 64'({m0_readdatavalid, m1_readdatavalid}),
                     64'((i % 2 == 1) ? 2'b10 : 2'b01));
    end
    drive('0, '0);
    chk("t2_last_rdv1", 64'(m1_readdatavalid), 64'(1));
    chk("t2_last_data", 64'(m1_readdata), 64'(32'h22222222));

    // 3: partial write
    drive('0, rq(0, 1, 0, 'h020, 4'hF, 32'hFFFFFFFF));
    drive('0, rq(0, 1, 0, 'h020, 4'h3, 32'h12345678));
    drive('0, rq(1, 0, 0, 'h020, 4'hF, 0));
    drive('0, '0);
    chk("t3_rdv1", 64'(m1_readdatavalid), 64'(1));
    chk("t3_data", 64'(m1_readdata), 64'(32'hFFFF5678));

    // 4: lock for three transfers keeps m1 out until the cycle after the lock drops
    for (int i = 0; i < 3; i++) begin
      drive(rq(0, 1, 1, 'h030 + i, 4'hF, 32'(i)), rq(1, 0, 0, 'h020, 4'hF, 0));
      chk("t4_m1_stall", 64'(m1_waitrequest), 64'(1));
    end
    drive('0, rq(1, 0, 0, 'h020, 4'hF, 0));
    chk("t4_unlock_cycle", 64'(m1_waitrequest), 64'(1));
    drive('0, rq(1, 0, 0, 'h020, 4'hF, 0));
    chk("t4_m1_grant", 64'(m1_waitrequest), 64'(0));
    drive('0, '0);

    // 5: forced release: 1 locking accept + 16 locked cycles before m1 gets in
    n = 0; found = 0;
    while (!found && n < 40) begin
      drive(rq(0, 1, 1, 'h040, 4'hF, 32'(n)), rq(1, 0, 0, 'h020, 4'hF, 0));
      if (!m1_waitrequest) found = 1;
      else n++;
    end
    chk("t5_stall_cycles", 64'(n), 64'(17));
    drive('0, '0);
    drive('0, '0);

    // 6: reset right after a read accept drops the return and clears rr_ptr
    drive(rq(1, 0, 0, 'h010, 4'hF, 0), '0);
    chk("t6_rd_accept", 64'(m0_waitrequest), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b0; q0 = '0; q1 = '0;
    @(negedge clk);
    chk("t6_no_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_no_rdv_after", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    drive(rq(1, 0, 0, 'h010, 4'hF, 0), rq(1, 0, 0, 'h020, 4'hF, 0));
    chk("t6_grant_m0", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b01));
    drive('0, '0);
    chk("t6_rdata", 64'(m0_readdata), 64'(32'hDEADBEEF));
    drive('0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
